// File: rtl/nabp_angle_scheduler.sv
// nabp_angle_scheduler
//
// Sequences the projection angles of one backprojection run. A kick in IDLE
// loads the first angle and the run length; angles are then offered one at a
// time to the swap control and advance by a fixed step, wrapping at
// ANGLE_MOD. Dispatched-but-unretired angles are counted so that dispatch
// pauses while every swappable is busy. When the last angle has been taken
// and retired, na_done pulses for one cycle in the first IDLE cycle.
//
// Handshake (hs_*): hs_angle_valid is a function of registered state only
// (state == SERVE and a free swappable). A transfer ("take") happens on a
// rising edge where hs_angle_valid and hs_next_angle_ack are both high;
// hs_next_angle_ack while hs_angle_valid is low has no effect. hs_angle and
// hs_has_next_angle hold their values until a take and change after that
// edge.
//
// Ports:
//   clk                in   clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   na_kick            in   start a run (ignored unless idle)
//   hs_angle           out  angle currently offered
//   hs_angle_valid     out  hs_angle may be taken this cycle
//   hs_next_angle_ack  in   consumer takes hs_angle
//   hs_has_next_angle  out  at least one more angle follows this one
//   sw_itr_done        in   one-cycle pulse: a swappable retired an angle
//   busy               out  run in progress
//   na_done            out  one-cycle pulse: run complete
//   err_underflow      out  sticky: retirement seen with nothing in flight
//
// The FSM state is held in r_state (type state_t) for external checkers.

module nabp_angle_scheduler #(
  parameter int ANGLE_WIDTH  = 8,
  parameter int ANGLE_COUNT  = 180,
  parameter int ANGLE_START  = 0,
  parameter int ANGLE_STEP   = 1,
  parameter int ANGLE_MOD    = 180,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   na_kick,
  output logic [ANGLE_WIDTH-1:0] hs_angle,
  output logic                   hs_angle_valid,
  input  logic                   hs_next_angle_ack,
  output logic                   hs_has_next_angle,
  input  logic                   sw_itr_done,
  output logic                   busy,
  output logic                   na_done,
  output logic                   err_underflow
);

  localparam int AW = ANGLE_WIDTH;
  localparam int RW = $clog2(ANGLE_COUNT + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_angle;
  logic [RW-1:0]   r_remaining;
  logic [IW-1:0]   r_inflight;
  logic            r_err_underflow;
  logic            r_done;

  logic            w_valid;
  logic            w_take;
  logic            w_start;
  logic            w_last_take;
  logic [IW-1:0]   w_inflight_next;
  logic            w_underflow;
  logic [AW:0]     w_angle_sum;
  logic [AW-1:0]   w_angle_next;
  logic            w_done_next;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign w_valid     = (r_state == ST_SERVE) && (r_inflight < IW'(MAX_INFLIGHT));
  assign w_take      = w_valid && hs_next_angle_ack;
  assign w_start     = (r_state == ST_IDLE) && na_kick;
  assign w_last_take = w_take && (r_remaining == RW'(1));

  // ---------------------------------------------------------------------------
  // Angle advance: the sum is formed one bit wider so that a step past the
  // top of the angle range (up to 2^ANGLE_WIDTH) cannot wrap silently before
  // the modulus compare.
  // ---------------------------------------------------------------------------
  assign w_angle_sum = {1'b0, r_angle} + (AW + 1)'(ANGLE_STEP);

  always_comb begin
    w_angle_next = AW'(w_angle_sum);
    if (w_angle_sum >= (AW + 1)'(ANGLE_MOD)) begin
      w_angle_next = AW'(w_angle_sum - (AW + 1)'(ANGLE_MOD));
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight tracking. A take and a retirement in the same cycle cancel.
  // A retirement with nothing in flight (and no take to pair with) is an
  // underflow: the count stays at zero and the sticky error is raised.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_inflight_next = r_inflight;
    w_underflow     = 1'b0;
    if (w_take && !sw_itr_done) begin
      w_inflight_next = r_inflight + IW'(1);
    end else if (!w_take && sw_itr_done) begin
      if (r_inflight != '0) begin
        w_inflight_next = r_inflight - IW'(1);
      end else begin
        w_underflow = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state. When the final take leaves nothing in flight, the drain
  // phase is skipped and the run completes on the take edge itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (na_kick) begin
          w_state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (w_last_take) begin
          if (w_inflight_next == '0) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_inflight_next == '0) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Completion pulse is registered so it appears in the first IDLE cycle.
  assign w_done_next = (r_state != ST_IDLE) && (w_state_next == ST_IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_angle     <= '0;
      r_remaining <= '0;
    end else if (w_start) begin
      r_angle     <= AW'(ANGLE_START);
      r_remaining <= RW'(ANGLE_COUNT);
    end else if (w_take) begin
      r_angle     <= w_angle_next;
      r_remaining <= r_remaining - RW'(1);
    end
  end

  // The in-flight count is deliberately not cleared by a kick: angles still
  // held by a swappable from an earlier run keep occupying it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight      <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_inflight <= w_inflight_next;
      if (w_underflow) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hs_angle          = r_angle;
  assign hs_angle_valid    = w_valid;
  assign hs_has_next_angle = (r_state == ST_SERVE) && (r_remaining > RW'(1));
  assign busy              = (r_state != ST_IDLE);
  assign na_done           = r_done;
  assign err_underflow     = r_err_underflow;

endmodule

// File: tb/tb_nabp_angle_scheduler.sv
// Testbench for nabp_angle_scheduler.
// Two instances: dut_a (4 angles, 0..3, step 1) for the run, backpressure,
// underflow and reset scenarios; dut_b (5 angles from 170, step 4, mod 180)
// for the wrap scenario. Inputs are driven 1 ns after the rising edge,
// outputs are sampled on the falling edge.

module tb_nabp_angle_scheduler;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_kick, a_ack, a_itr;
  logic [7:0] a_angle;
  logic       a_valid, a_has_next, a_busy, a_done, a_err;

  logic       b_kick, b_ack, b_itr;
  logic [7:0] b_angle;
  logic       b_valid, b_has_next, b_busy, b_done, b_err;

  nabp_angle_scheduler #(
    .ANGLE_WIDTH (8),
    .ANGLE_COUNT (4),
    .ANGLE_START (0),
    .ANGLE_STEP  (1),
    .ANGLE_MOD   (180),
    .MAX_INFLIGHT(2)
  ) dut_a (
    .clk              (clk),
    .reset_n          (reset_n),
    .na_kick          (a_kick),
    .hs_angle         (a_angle),
    .hs_angle_valid   (a_valid),
    .hs_next_angle_ack(a_ack),
    .hs_has_next_angle(a_has_next),
    .sw_itr_done      (a_itr),
    .busy             (a_busy),
    .na_done          (a_done),
    .err_underflow    (a_err)
  );

  nabp_angle_scheduler #(
    .ANGLE_WIDTH (8),
    .ANGLE_COUNT (5),
    .ANGLE_START (170),
    .ANGLE_STEP  (4),
    .ANGLE_MOD   (180),
    .MAX_INFLIGHT(2)
  ) dut_b (
    .clk              (clk),
    .reset_n          (reset_n),
    .na_kick          (b_kick),
    .hs_angle         (b_angle),
    .hs_angle_valid   (b_valid),
    .hs_next_angle_ack(b_ack),
    .hs_has_next_angle(b_has_next),
    .sw_itr_done      (b_itr),
    .busy             (b_busy),
    .na_done          (b_done),
    .err_underflow    (b_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic [0:0] exp_hn_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: each call is one clock cycle. Inputs change 1 ns after the
  // rising edge; the task returns at the falling edge so outputs can be read.
  // ---------------------------------------------------------------------------
  task automatic cycle_a(input logic ack, input logic itr, input logic kick);
    @(posedge clk);
    #1;
    a_ack  = ack;
    a_itr  = itr;
    a_kick = kick;
    @(negedge clk);
  endtask

  task automatic cycle_b(input logic ack, input logic itr, input logic kick);
    @(posedge clk);
    #1;
    b_ack  = ack;
    b_itr  = itr;
    b_kick = kick;
    @(negedge clk);
  endtask

  // On a take in dut_b's current cycle, compare against the scoreboard.
  task automatic score_b(input string tag);
    if (b_valid && b_ack) begin
      if (exp_q.size() == 0) begin
        check({tag, "_extra_take"}, 1, 0);
      end else begin
        check({tag, "_angle"}, b_angle, exp_q.pop_front());
        check({tag, "_has_next"}, b_has_next, exp_hn_q.pop_front());
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit sched [0:63];
    int takes, retires, last_ret, done_cnt, done_cyc;

    a_kick = 0; a_ack = 0; a_itr = 0;
    b_kick = 0; b_ack = 0; b_itr = 0;
    #12;
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_angle", a_angle, 0);
    check("rst_valid", a_valid, 0);
    check("rst_has_next", a_has_next, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_b_busy", b_busy, 0);

    // ---- Basic run: ack every cycle, retirement 2 cycles after each take ----
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    exp_hn_q = '{1'b1, 1'b1, 1'b1, 1'b0};
    foreach (sched[i]) sched[i] = 1'b0;
    takes = 0; retires = 0; last_ret = -1; done_cnt = 0; done_cyc = -1;
    cycle_a(0, 0, 1);
    for (int cyc = 0; cyc < 14; cyc++) begin
      cycle_a(1, sched[cyc], 0);
      if (cyc == 0) begin
        check("kick_busy", a_busy, 1);
        check("kick_valid", a_valid, 1);
        check("kick_angle", a_angle, 0);
      end
      if (a_itr) begin
        retires++;
        if (retires == 4) last_ret = cyc;
      end
      if (a_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (a_valid && a_ack) begin
        takes++;
        sched[cyc + 2] = 1'b1;
        if (exp_q.size() == 0) begin
          check("basic_extra_take", 1, 0);
        end else begin
          check("basic_angle", a_angle, exp_q.pop_front());
          check("basic_has_next", a_has_next, exp_hn_q.pop_front());
        end
      end
    end
    check("basic_takes", takes, 4);
    check("basic_retires", retires, 4);
    check("basic_done_count", done_cnt, 1);
    check("basic_done_cycle", done_cyc, last_ret + 1);
    check("basic_idle", a_busy, 0);
    cycle_a(0, 0, 0);

    // ---- Wrap run on dut_b: 170,174,178,2,6 ----
    exp_q = '{8'd170, 8'd174, 8'd178, 8'd2, 8'd6};
    exp_hn_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cycle_b(0, 0, 1);
    cycle_b(1, 0, 0); score_b("wrap0");
    cycle_b(1, 1, 0); score_b("wrap1");
    cycle_b(1, 1, 0); score_b("wrap2");
    cycle_b(1, 1, 0); score_b("wrap3");
    cycle_b(1, 1, 0); score_b("wrap4");
    cycle_b(0, 1, 0);
    check("wrap_drain_valid", b_valid, 0);
    check("wrap_drain_busy", b_busy, 1);
    check("wrap_drain_done", b_done, 0);
    cycle_b(0, 0, 0);
    check("wrap_done", b_done, 1);
    check("wrap_idle", b_busy, 0);
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_err", b_err, 0);
    cycle_b(0, 0, 0);
    check("wrap_done_single", b_done, 0);

    // ---- Backpressure, simultaneous take+retire, kick during SERVE ----
    cycle_a(0, 0, 1);
    cycle_a(1, 0, 0);
    check("bp_c0_valid", a_valid, 1);
    check("bp_c0_angle", a_angle, 0);
    cycle_a(1, 0, 1);
    check("bp_c1_valid", a_valid, 1);
    check("bp_c1_angle", a_angle, 1);
    cycle_a(1, 0, 0);
    check("bp_full_valid", a_valid, 0);
    check("bp_kick_ignored_angle", a_angle, 2);
    check("bp_kick_ignored_has_next", a_has_next, 1);
    cycle_a(1, 0, 0);
    check("bp_full_valid2", a_valid, 0);
    cycle_a(1, 1, 0);
    check("bp_retire_cycle_valid", a_valid, 0);
    cycle_a(1, 1, 0);
    check("bp_resume_valid", a_valid, 1);
    check("bp_resume_angle", a_angle, 2);
    cycle_a(1, 0, 0);
    check("simul_valid", a_valid, 1);
    check("simul_angle", a_angle, 3);
    check("simul_has_next", a_has_next, 0);
    cycle_a(0, 1, 0);
    check("bp_drain_valid", a_valid, 0);
    check("bp_drain_busy", a_busy, 1);
    cycle_a(0, 1, 0);
    check("bp_drain_done", a_done, 0);
    cycle_a(0, 0, 0);
    check("bp_done", a_done, 1);
    check("bp_idle", a_busy, 0);
    cycle_a(0, 0, 0);
    check("bp_done_single", a_done, 0);

    // ---- Underflow in IDLE, then a full run with the flag held ----
    check("uf_before", a_err, 0);
    cycle_a(0, 1, 0);
    cycle_a(0, 0, 0);
    check("uf_set", a_err, 1);
    check("uf_idle", a_busy, 0);
    cycle_a(0, 0, 1);
    cycle_a(1, 0, 0);
    check("uf_run_c0_valid", a_valid, 1);
    check("uf_run_c0_angle", a_angle, 0);
    cycle_a(1, 0, 0);
    check("uf_run_c1_valid", a_valid, 1);
    cycle_a(1, 0, 0);
    check("uf_inflight_zero", a_valid, 0);
    cycle_a(1, 1, 0);
    check("uf_held_run", a_err, 1);
    cycle_a(1, 1, 0);
    check("uf_c4_angle", a_angle, 2);
    cycle_a(1, 1, 0);
    check("uf_c5_angle", a_angle, 3);
    cycle_a(0, 1, 0);
    check("uf_drain_busy", a_busy, 1);
    // Kick in the same cycle as na_done must start a new run.
    cycle_a(0, 0, 1);
    check("uf_done", a_done, 1);
    check("uf_held_after", a_err, 1);

    // ---- New run accepted during na_done, then reset mid-SERVE ----
    cycle_a(1, 0, 0);
    check("rekick_busy", a_busy, 1);
    check("rekick_angle", a_angle, 0);
    cycle_a(0, 0, 0);
    check("pre_reset_angle", a_angle, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_angle", a_angle, 0);
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_has_next", a_has_next, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_done", a_done, 0);
    check("mid_rst_err", a_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle_a(0, 0, 0);
    check("post_rst_busy", a_busy, 0);
    check("post_rst_done", a_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
